// File: rtl/rshift_unit.sv
// Multi-cycle right shifter: one bit per clock, logical (sh_in fill) or arithmetic (sign fill).
// Optional feature: define RSH_STICKY_EN to add the sticky output (OR of all bits shifted out).
`timescale 1ns/1ps

module rshift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] amount,
    input  logic             arith,
    input  logic             sh_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             sh_out
`ifdef RSH_STICKY_EN
    ,
    output logic             sticky
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             arith_q,  arith_d;
    logic             sh_in_q,  sh_in_d;
    logic             sh_out_q, sh_out_d;

    logic accept;
    logic fill;

    // Only an idle unit accepts work; start in SHIFT or DONE is dropped.
    assign accept = (state_q == ST_IDLE) && start;
    assign fill   = arith_q ? data_q[WIDTH-1] : sh_in_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        arith_d  = arith_q;
        sh_in_d  = sh_in_q;
        sh_out_d = sh_out_q;
        if (accept) begin
            data_d   = din;
            cnt_d    = amount;
            arith_d  = arith;
            sh_in_d  = sh_in;
            sh_out_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            data_d   = {fill, data_q[WIDTH-1:1]};
            sh_out_d = data_q[0];
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_q   <= '0;
            cnt_q    <= '0;
            arith_q  <= 1'b0;
            sh_in_q  <= 1'b0;
            sh_out_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            arith_q  <= arith_d;
            sh_in_q  <= sh_in_d;
            sh_out_q <= sh_out_d;
        end
    end

`ifdef RSH_STICKY_EN
    logic sticky_q, sticky_d;

    // Rounding hint: remembers whether any 1 ever left through bit 0.
    always_comb begin
        sticky_d = sticky_q;
        if (accept) begin
            sticky_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            sticky_d = sticky_q | data_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign dout   = data_q;
    assign sh_out = sh_out_q;

`ifndef SYNTHESIS
    // A zero count can never be live in SHIFT: it is diverted straight to DONE.
    a_cnt_nonzero: assert property (@(posedge clk) disable iff (!rst_b)
        (state_q == ST_SHIFT) |-> (cnt_q != '0));

    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_b)
        done |=> !done);
`endif

endmodule
